// File: rtl/zorro_ac_pkg.sv
// Shared definitions for the Zorro III AUTOCONFIG responder: register offsets,
// FSM state encoding, default manufacturer IDs and a width helper.
package zorro_ac_pkg;

    localparam int unsigned AD_W   = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MNF_W  = 16;
    localparam int unsigned SER_W  = 32;

    localparam logic [AD_W-1:0] AC_TYPE   = 8'h00;
    localparam logic [AD_W-1:0] AC_SIZE   = 8'h02;
    localparam logic [AD_W-1:0] AC_PID_H  = 8'h04;
    localparam logic [AD_W-1:0] AC_PID_L  = 8'h06;
    localparam logic [AD_W-1:0] AC_FLAGS  = 8'h08;
    localparam logic [AD_W-1:0] AC_MNF0   = 8'h10;
    localparam logic [AD_W-1:0] AC_MNF1   = 8'h12;
    localparam logic [AD_W-1:0] AC_MNF2   = 8'h14;
    localparam logic [AD_W-1:0] AC_MNF3   = 8'h16;
    localparam logic [AD_W-1:0] AC_SER0   = 8'h18;
    localparam logic [AD_W-1:0] AC_SER1   = 8'h1A;
    localparam logic [AD_W-1:0] AC_SER2   = 8'h1C;
    localparam logic [AD_W-1:0] AC_SER3   = 8'h1E;
    localparam logic [AD_W-1:0] AC_SER4   = 8'h20;
    localparam logic [AD_W-1:0] AC_SER5   = 8'h22;
    localparam logic [AD_W-1:0] AC_SER6   = 8'h24;
    localparam logic [AD_W-1:0] AC_SER7   = 8'h26;
    localparam logic [AD_W-1:0] AC_BASE_H = 8'h48;
    localparam logic [AD_W-1:0] AC_BASE_L = 8'h4A;
    localparam logic [AD_W-1:0] AC_SHUTUP = 8'h4C;

    localparam logic [MNF_W-1:0] MNF_ID_DEFAULT = 16'd600;
    localparam logic [MNF_W-1:0] MNF_ID_ALT     = 16'd3643;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_COMMIT,
        ST_ACK
    } ac_state_e;

    // Board-index width; a single-board instance still needs one bit.
    function automatic int unsigned cur_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zorro_autoconfig_chain_if.sv
// Local-bus signals of one AUTOCONFIG slot, seen from the bus (master) and
// from the responder (slave).
interface zorro_autoconfig_chain_if;
    logic       AUTOCONFIG_SPACE;
    logic       TSn;
    logic       RnW;
    logic [6:0] A;
    logic [3:0] D_IN;
    logic [3:0] D_OUT;
    logic       AC_TACK;

    modport master (
        output AUTOCONFIG_SPACE, TSn, RnW, A, D_IN,
        input  D_OUT, AC_TACK
    );

    modport slave (
        input  AUTOCONFIG_SPACE, TSn, RnW, A, D_IN,
        output D_OUT, AC_TACK
    );
endinterface

// File: rtl/zorro_ac_rom.sv
// Combinational configuration-ROM nibble for the board currently offered.
module zorro_ac_rom
    import zorro_ac_pkg::*;
#(
    parameter int unsigned                 NUM_DEV   = 3,
    parameter logic [8*NUM_DEV-1:0]        DEV_TYPE  = {8'hC0, 8'hC1, 8'h80},
    parameter logic [8*NUM_DEV-1:0]        DEV_PID   = {8'd200, 8'd3, 8'd4},
    parameter logic [8*NUM_DEV-1:0]        DEV_FLAGS = {8'h70, 8'h40, 8'hC0},
    parameter logic [16*NUM_DEV-1:0]       DEV_MNF   = {MNF_ID_ALT, MNF_ID_DEFAULT, MNF_ID_DEFAULT},
    parameter logic [NUM_DEV-1:0]          DEV_BOOT  = 3'b010,
    parameter logic [31:0]                 SERNUM    = 32'd1
) (
    input  logic [AD_W-1:0]                ad,
    input  logic [cur_width(NUM_DEV)-1:0]  cur_dev,
    input  logic                           autoboot,
    output logic [NIB_W-1:0]               nibble_c
);

    localparam int unsigned CUR_W = cur_width(NUM_DEV);

    logic [BYTE_W-1:0] typ;
    logic [BYTE_W-1:0] pid;
    logic [BYTE_W-1:0] flg;
    logic [MNF_W-1:0]  mnf;
    logic              boot;

    // Pick the current board's fields with constant slices only.
    always_comb begin
        typ  = '0;
        pid  = '0;
        flg  = '0;
        mnf  = '0;
        boot = 1'b0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            if (cur_dev == CUR_W'(i)) begin
                typ  = DEV_TYPE[8*i +: 8];
                pid  = DEV_PID[8*i +: 8];
                flg  = DEV_FLAGS[8*i +: 8];
                mnf  = DEV_MNF[16*i +: 16];
                boot = DEV_BOOT[i];
            end
        end
    end

    // Everything past the type/size nibbles is stored inverted.
    always_comb begin
        nibble_c = 4'hF;
        case (ad)
            AC_TYPE:  nibble_c = typ[7:4] | {3'b000, boot & autoboot};
            AC_SIZE:  nibble_c = typ[3:0];
            AC_PID_H: nibble_c = ~pid[7:4];
            AC_PID_L: nibble_c = ~pid[3:0];
            AC_FLAGS: nibble_c = ~flg[7:4];
            AC_MNF0:  nibble_c = ~mnf[15:12];
            AC_MNF1:  nibble_c = ~mnf[11:8];
            AC_MNF2:  nibble_c = ~mnf[7:4];
            AC_MNF3:  nibble_c = ~mnf[3:0];
            AC_SER0:  nibble_c = ~SERNUM[31:28];
            AC_SER1:  nibble_c = ~SERNUM[27:24];
            AC_SER2:  nibble_c = ~SERNUM[23:20];
            AC_SER3:  nibble_c = ~SERNUM[19:16];
            AC_SER4:  nibble_c = ~SERNUM[15:12];
            AC_SER5:  nibble_c = ~SERNUM[11:8];
            AC_SER6:  nibble_c = ~SERNUM[7:4];
            AC_SER7:  nibble_c = ~SERNUM[3:0];
            default:  nibble_c = 4'hF;
        endcase
    end

endmodule

// File: rtl/zorro_autoconfig_chain.sv
// Zorro III AUTOCONFIG responder presenting NUM_DEV logical boards in turn
// from one slot; latches each base address and chains CONFIGENn onward.
module zorro_autoconfig_chain
    import zorro_ac_pkg::*;
#(
    parameter int unsigned                 NUM_DEV   = 3,
    parameter logic [8*NUM_DEV-1:0]        DEV_TYPE  = {8'hC0, 8'hC1, 8'h80},
    parameter logic [8*NUM_DEV-1:0]        DEV_PID   = {8'd200, 8'd3, 8'd4},
    parameter logic [8*NUM_DEV-1:0]        DEV_FLAGS = {8'h70, 8'h40, 8'hC0},
    parameter logic [16*NUM_DEV-1:0]       DEV_MNF   = {MNF_ID_ALT, MNF_ID_DEFAULT, MNF_ID_DEFAULT},
    parameter logic [NUM_DEV-1:0]          DEV_BOOT  = 3'b010,
    parameter logic [31:0]                 SERNUM    = 32'd1
) (
    input  logic                           CLK40,
    input  logic                           RESETn,
    zorro_autoconfig_chain_if.slave        bus,
    input  logic                           CPUCONFn,
    input  logic                           AUTOBOOT,
    output logic                           CONFIGENn,
    output logic                           CONFIGURED,
    output logic [NUM_DEV-1:0]             DEV_CONF,
    output logic [NUM_DEV-1:0]             DEV_SHUT,
    output logic [8*NUM_DEV-1:0]           DEV_BASE,
    output logic [cur_width(NUM_DEV)-1:0]  CUR_DEV
);

    localparam int unsigned          CUR_W    = cur_width(NUM_DEV);
    localparam logic [CUR_W-1:0]     LAST_DEV = CUR_W'(NUM_DEV - 1);

    ac_state_e          state, state_nxt;
    logic               ts_q;
    logic               ac_start;
    logic               rnw_q;
    logic [6:0]         a_q;
    logic [AD_W-1:0]    ad;
    logic [NIB_W-1:0]   lo_q;
    logic [NIB_W-1:0]   d_out_q;
    logic [NIB_W-1:0]   rom_nib_c;
    logic               tack_q;
    logic               tack_nxt;
    logic               load_rd;
    logic               commit;

    assign ad          = {a_q, 1'b0};
    assign bus.D_OUT   = d_out_q;
    assign bus.AC_TACK = tack_q;

    zorro_ac_rom #(
        .NUM_DEV   (NUM_DEV),
        .DEV_TYPE  (DEV_TYPE),
        .DEV_PID   (DEV_PID),
        .DEV_FLAGS (DEV_FLAGS),
        .DEV_MNF   (DEV_MNF),
        .DEV_BOOT  (DEV_BOOT),
        .SERNUM    (SERNUM)
    ) u_rom (
        .ad       (ad),
        .cur_dev  (CUR_DEV),
        .autoboot (AUTOBOOT),
        .nibble_c (rom_nib_c)
    );

    // Capture the transfer start; only an idle responder listens, so no queueing.
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            ts_q     <= 1'b0;
            ac_start <= 1'b0;
            rnw_q    <= 1'b1;
            a_q      <= '0;
        end else begin
            ts_q     <= (state == ST_IDLE) && bus.AUTOCONFIG_SPACE && !bus.TSn;
            ac_start <= !CONFIGURED && ts_q;
            if ((state == ST_IDLE) && bus.AUTOCONFIG_SPACE && !bus.TSn) begin
                a_q   <= bus.A;
                rnw_q <= bus.RnW;
            end
        end
    end

    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_rd   = 1'b0;
        commit    = 1'b0;
        tack_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ac_start && !CPUCONFn) begin
                    if (rnw_q) begin
                        state_nxt = ST_RD;
                        load_rd   = 1'b1;
                    end else begin
                        state_nxt = ST_WR;
                    end
                end
            end
            ST_RD: begin
                state_nxt = ST_IDLE;
                tack_nxt  = 1'b1;
            end
            ST_WR: begin
                state_nxt = ST_COMMIT;
                commit    = 1'b1;
            end
            ST_COMMIT: begin
                state_nxt = ST_ACK;
                tack_nxt  = 1'b1;
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-board state; a base or shut-up write retires the current board.
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            tack_q     <= 1'b0;
            d_out_q    <= '0;
            lo_q       <= '0;
            CONFIGURED <= 1'b0;
            CONFIGENn  <= 1'b1;
            DEV_CONF   <= '0;
            DEV_SHUT   <= '0;
            DEV_BASE   <= '0;
            CUR_DEV    <= '0;
        end else begin
            tack_q <= tack_nxt;
            if (load_rd) d_out_q <= rom_nib_c;
            if (commit) begin
                case (ad)
                    AC_BASE_L: lo_q <= bus.D_IN;
                    AC_BASE_H, AC_SHUTUP: begin
                        for (int unsigned i = 0; i < NUM_DEV; i++) begin
                            if (CUR_DEV == CUR_W'(i)) begin
                                if (ad == AC_BASE_H) begin
                                    DEV_BASE[8*i +: 8] <= {bus.D_IN, lo_q};
                                    DEV_CONF[i]        <= 1'b1;
                                end else begin
                                    DEV_SHUT[i] <= 1'b1;
                                end
                            end
                        end
                        lo_q <= '0;
                        if (CUR_DEV == LAST_DEV) begin
                            CONFIGURED <= 1'b1;
                            CONFIGENn  <= 1'b0;
                            d_out_q    <= 4'hF;
                        end else begin
                            CUR_DEV <= CUR_DEV + CUR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
